// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: control and LED-drive signals of the LED pattern sequencer
//   run     : 1 = free-running stepping, 0 = paused
//   step    : level input, each rising edge advances one step while paused
//   mode    : 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar-fill
//   period  : prescaler terminal count, 0 selects the fallback period
//   led     : registered LED drive
//   tick_o  : one-cycle pulse on every pattern advance
// master drives the controls, slave is the sequencer.
interface led_pattern_seq_if #(
   parameter int LED_NUM     = 6,
   parameter int COUNT_WIDTH = 32
);
   logic                   run;
   logic                   step;
   logic [1:0]             mode;
   logic [COUNT_WIDTH-1:0] period;
   logic [LED_NUM-1:0]     led;
   logic                   tick_o;

   modport master (output run, step, mode, period, input led, tick_o);
   modport slave  (input run, step, mode, period, output led, tick_o);
endinterface

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: drives LED_NUM LEDs through one of four patterns at a programmable step rate
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   io     : slave side of led_pattern_seq_if (run, step, mode, period in; led, tick_o out)
module led_pattern_seq #(
   parameter int LED_NUM     = 6,
   parameter int COUNT_WIDTH = 32,
   parameter int COUNT_MAX   = 27_000_000,
   parameter int LED_MODE    = 0
) (
   input logic              clk,
   input logic              rst_n,
   led_pattern_seq_if.slave io
);
   localparam int                     PW   = $clog2(LED_NUM + 1);
   localparam logic [PW-1:0]          LAST = PW'(LED_NUM - 1);
   localparam logic [PW-1:0]          FULL = PW'(LED_NUM);
   localparam logic [COUNT_WIDTH-1:0] CMAX = COUNT_WIDTH'(COUNT_MAX);

   logic [COUNT_WIDTH-1:0] cnt, lim;
   logic [PW-1:0]          pos, pos_n;
   logic [1:0]             mode_q;
   logic [LED_NUM-1:0]     pat;
   logic                   tick, step_q, dir, dir_n, mode_chg, adv;

   always_comb begin
      lim      = (io.period == '0) ? CMAX : io.period;
      mode_chg = io.mode != mode_q;
      adv      = (io.run & tick) | (~io.run & io.step & ~step_q);
      pat      = (mode_q == 2'd3) ? ~({LED_NUM{1'b1}} << pos) : LED_NUM'(1) << pos;
   end

   // dir: 0 = up, 1 = down; only ping-pong uses it
   always_comb begin
      pos_n = pos;
      dir_n = dir;
      case (mode_q)
         2'd0: pos_n = (pos == LAST) ? '0 : pos + 1'b1;
         2'd1: pos_n = (pos == '0) ? LAST : pos - 1'b1;
         2'd2: begin
            // reverse at the ends so the end LEDs are not shown twice
            pos_n = dir ? ((pos == '0) ? PW'(1) : pos - 1'b1)
                        : ((pos == LAST) ? pos - 1'b1 : pos + 1'b1);
            dir_n = dir ? (pos != '0) : (pos == LAST);
         end
         default: pos_n = (pos == FULL) ? '0 : pos + 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         tick      <= 1'b0;
         pos       <= '0;
         dir       <= 1'b0;
         step_q    <= 1'b0;
         mode_q    <= 2'd0;
         io.tick_o <= 1'b0;
         io.led    <= (LED_MODE != 0) ? '0 : '1;
      end else begin
         step_q    <= io.step;
         mode_q    <= io.mode;
         io.led    <= (LED_MODE != 0) ? pat : ~pat;
         // a mode change restarts the pattern and swallows any coincident advance
         io.tick_o <= adv & ~mode_chg;
         if (mode_chg) begin
            pos  <= '0;
            dir  <= 1'b0;
            cnt  <= '0;
            tick <= 1'b0;
         end else begin
            if (adv) begin
               pos <= pos_n;
               dir <= dir_n;
            end
            if (io.run) cnt <= (cnt == lim) ? '0 : cnt + 1'b1;
            tick <= io.run & (cnt == lim);
         end
      end
   end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed self-checking bench for led_pattern_seq (active-high and active-low LED builds)
module tb_led_pattern_seq;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       run, step;
   logic [1:0] mode;
   logic [7:0] period;
   int         n_chk = 0;
   int         n_fail = 0;

   led_pattern_seq_if #(.LED_NUM(4), .COUNT_WIDTH(8)) ia ();
   led_pattern_seq_if #(.LED_NUM(4), .COUNT_WIDTH(8)) ib ();

   assign ia.run = run;
   assign ia.step = step;
   assign ia.mode = mode;
   assign ia.period = period;
   assign ib.run = run;
   assign ib.step = step;
   assign ib.mode = mode;
   assign ib.period = period;

   led_pattern_seq #(.LED_NUM(4), .COUNT_WIDTH(8), .COUNT_MAX(5), .LED_MODE(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .io(ia.slave));
   led_pattern_seq #(.LED_NUM(4), .COUNT_WIDTH(8), .COUNT_MAX(5), .LED_MODE(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .io(ib.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ia.tick_o && n < 50);
      check("tick_seen", ia.tick_o, 1);
   endtask

   task automatic adv_chk(input string tag, input int gap, input logic [3:0] exp);
      int         n;
      logic [3:0] inv;
      inv = ~exp;
      wait_tick(n);
      check({tag, "_gap"}, n, gap);
      @(negedge clk);
      check({tag, "_pulse"}, ia.tick_o, 0);
      check({tag, "_led"}, ia.led, exp);
      check({tag, "_ledn"}, ib.led, inv);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_n = 1'b0; run = 1'b1; step = 1'b0; mode = 2'd0; period = 8'd3;
      repeat (3) @(negedge clk);
      check("rst_led", ia.led, 4'b0000);
      check("rst_ledn", ib.led, 4'b1111);
      check("rst_tick", ia.tick_o, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst", ia.led, 4'b0001);
      adv_chk("rotl0", 4, 4'b0010);
      adv_chk("rotl1", 3, 4'b0100);
      adv_chk("rotl2", 3, 4'b1000);
      adv_chk("rotl3", 3, 4'b0001);

      mode = 2'd2;
      adv_chk("pp0", 6, 4'b0010);
      adv_chk("pp1", 3, 4'b0100);
      adv_chk("pp2", 3, 4'b1000);
      adv_chk("pp3", 3, 4'b0100);
      adv_chk("pp4", 3, 4'b0010);
      adv_chk("pp5", 3, 4'b0001);
      adv_chk("pp6", 3, 4'b0010);

      mode = 2'd3;
      adv_chk("bar0", 6, 4'b0001);
      adv_chk("bar1", 3, 4'b0011);
      adv_chk("bar2", 3, 4'b0111);
      adv_chk("bar3", 3, 4'b1111);
      adv_chk("bar4", 3, 4'b0000);

      run = 1'b0;
      t = 0;
      step = 1'b1;
      repeat (10) begin @(negedge clk); t += int'(ia.tick_o); end
      step = 1'b0;
      repeat (3) begin @(negedge clk); t += int'(ia.tick_o); end
      check("step_hold", ia.led, 4'b0001);
      step = 1'b1;
      @(negedge clk); t += int'(ia.tick_o);
      step = 1'b0;
      repeat (4) begin @(negedge clk); t += int'(ia.tick_o); end
      check("step_p1", ia.led, 4'b0011);
      step = 1'b1;
      @(negedge clk); t += int'(ia.tick_o);
      step = 1'b0;
      repeat (4) begin @(negedge clk); t += int'(ia.tick_o); end
      check("step_p2", ia.led, 4'b0111);
      check("step_cnt", t, 3);

      run = 1'b1;
      adv_chk("resume", 3, 4'b1111);

      mode = 2'd0; period = 8'd0;
      adv_chk("p0a", 8, 4'b0010);
      adv_chk("p0b", 5, 4'b0100);
      repeat (4) @(negedge clk);
      mode = 2'd1;
      @(negedge clk);
      check("mchg_noadv", ia.tick_o, 0);
      @(negedge clk);
      check("mchg_led", ia.led, 4'b0001);
      check("mchg_ledn", ib.led, 4'b1110);
      adv_chk("rr0", 6, 4'b1000);
      adv_chk("rr1", 5, 4'b0100);

      mode = 2'd2; period = 8'd3;
      adv_chk("ar0", 6, 4'b0010);
      adv_chk("ar1", 3, 4'b0100);
      adv_chk("ar2", 3, 4'b1000);
      adv_chk("ar3", 3, 4'b0100);
      #2 rst_n = 1'b0;
      #1;
      check("arst_led", ia.led, 4'b0000);
      check("arst_ledn", ib.led, 4'b1111);
      check("arst_tick", ia.tick_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_post", ia.led, 4'b0001);
      adv_chk("ar4", 5, 4'b0010);
      adv_chk("ar5", 3, 4'b0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
